dma_desc_sequencer: RTL

DMA_DESC_SEQUENCER -- requirements
Module: dma_desc_sequencer

---
 rtl/dma_desc_sequencer.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/dma_desc_sequencer.sv
// dma_desc_sequencer: turns one tile request into a series of DMA descriptors.
// Filter and bias tiles get one contiguous descriptor. Channel-planar kinds get
// one descriptor per channel. The first address is computed at start. Each
// following address is the previous one plus a precomputed plane stride.
// Optional feature macro: DMA_DESC_SEQ_RANGE_CHECK_EN. When it is defined,
// address overflow raises a sticky err_o and the sequence ends early.
// When it is undefined, addresses wrap and err_o is tied low.
//
// Descriptor handshake: a descriptor transfers on a rising edge where
// desc_valid_o && desc_ready_i. Once desc_valid_o rises, it stays high and
// desc_addr_o/desc_len_o/desc_last_o stay constant until that transfer.
// desc_valid_o never depends combinationally on desc_ready_i.
module dma_desc_sequencer #(
  parameter int ADDR_W     = 32,
  parameter int LEN_W      = 32,
  parameter int CH_W       = 7,
  parameter int PSUM_BYTES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [2:0]        kind_i,
  input  logic              stride2_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [LEN_W-1:0]  plane_i,
  input  logic [LEN_W-1:0]  elem_off_i,
  input  logic [LEN_W-1:0]  tile_n_i,
  input  logic [15:0]       ch_start_i,
  input  logic [CH_W-1:0]   tile_ch_i,
  output logic              desc_valid_o,
  input  logic              desc_ready_i,
  output logic [ADDR_W-1:0] desc_addr_o,
  output logic [LEN_W-1:0]  desc_len_o,
  output logic              desc_last_o,
  input  logic              dma_done_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [1:0]        state_o
);

  // The wide intermediate width holds the full offset arithmetic.
  // This lets an overflow past ADDR_W be seen rather than silently dropped.
  localparam int WIDE = ADDR_W + LEN_W + 24;

`ifdef DMA_DESC_SEQ_RANGE_CHECK_EN
  localparam bit RANGE_CHK = 1'b1;
`else
  localparam bit RANGE_CHK = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [WIDE-1:0]   step_q;
  logic [CH_W-1:0]   ch_cnt_q;
  logic [CH_W-1:0]   tile_ch_q;
  logic              single_q;

  // Decode of the request presented on the start cycle.
  logic              start_acc;
  logic              is_psum;
  logic              is_single;
  logic [WIDE-1:0]   esz_w;
  logic [LEN_W-1:0]  esz_l;
  logic [LEN_W-1:0]  len_base;
  logic [WIDE-1:0]   first_w;
  logic [WIDE-1:0]   step_w;
  logic [WIDE-1:0]   next_w;
  logic              first_ovf;
  logic              next_ovf;
  logic              first_err;
  logic              next_err;
  logic              last_q;
  logic              wait_done;

  assign start_acc = start_i && (state_q == S_IDLE);
  assign is_psum   = (kind_i == 3'd2) || (kind_i == 3'd3) || (kind_i == 3'd4);
  assign is_single = (kind_i == 3'd0) || (kind_i == 3'd2);
  assign esz_w     = is_psum ? WIDE'(PSUM_BYTES) : WIDE'(1);
  assign esz_l     = is_psum ? LEN_W'(PSUM_BYTES) : LEN_W'(1);
  assign len_base  = ((kind_i == 3'd5) && stride2_i) ? (tile_n_i >> 1) : tile_n_i;

  // The multiply happens only here, once per start. The loop below only adds.
  assign first_w   = WIDE'(base_addr_i) +
                     (WIDE'(ch_start_i) * WIDE'(plane_i) + WIDE'(elem_off_i)) * esz_w;
  assign step_w    = WIDE'(plane_i) * esz_w;
  assign next_w    = WIDE'(addr_q) + step_q;
  assign first_ovf = |first_w[WIDE-1:ADDR_W];
  assign next_ovf  = |next_w[WIDE-1:ADDR_W];
  assign first_err = RANGE_CHK && first_ovf;
  assign next_err  = RANGE_CHK && next_ovf;

  assign last_q    = single_q || (ch_cnt_q == (tile_ch_q - CH_W'(1)));
  assign wait_done = (state_q == S_WAIT) && dma_done_i;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic. Starts are ignored outside IDLE and DMA completions outside WAIT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (is_single)                               state_d = S_ISSUE;
          else if ((tile_ch_i == '0) || first_err)     state_d = S_DONE;
          else                                         state_d = S_ISSUE;
        end
      end
      S_ISSUE: if (desc_ready_i) state_d = S_WAIT;
      S_WAIT: begin
        if (dma_done_i) begin
          if (last_q || next_err) state_d = S_DONE;
          else                    state_d = S_ISSUE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Descriptor datapath: capture the request at start, step the address per channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      len_q     <= '0;
      step_q    <= '0;
      ch_cnt_q  <= '0;
      tile_ch_q <= '0;
      single_q  <= 1'b0;
    end else if (start_acc) begin
      addr_q    <= is_single ? base_addr_i : first_w[ADDR_W-1:0];
      len_q     <= len_base * esz_l;
      step_q    <= step_w;
      ch_cnt_q  <= '0;
      tile_ch_q <= tile_ch_i;
      single_q  <= is_single;
    end else if (wait_done && !last_q) begin
      addr_q   <= next_w[ADDR_W-1:0];
      ch_cnt_q <= ch_cnt_q + CH_W'(1);
    end
  end

`ifdef DMA_DESC_SEQ_RANGE_CHECK_EN
  logic err_q;

  // Sticky overflow flag. It clears only when a new request is accepted.
  always_ff @(posedge clk) begin
    if (rst)                                  err_q <= 1'b0;
    else if (start_acc)                       err_q <= !is_single && (tile_ch_i != '0) && first_err;
    else if (wait_done && !last_q && next_err) err_q <= 1'b1;
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  // Output decode from the registered state.
  always_comb begin
    desc_valid_o = (state_q == S_ISSUE);
    desc_last_o  = (state_q == S_ISSUE) && last_q;
    busy_o       = (state_q == S_ISSUE) || (state_q == S_WAIT);
    done_o       = (state_q == S_DONE);
    desc_addr_o  = addr_q;
    desc_len_o   = len_q;
    state_o      = state_q;
  end

endmodule
